// File: rtl/gray_pkg.sv
// Shared mode encoding, default weights and rounding helper for the RGB-to-gray pipeline.
package gray_pkg;

   typedef enum logic [1:0] {
      GRAY_LUMA  = 2'd0,
      GRAY_AVG   = 2'd1,
      GRAY_MAX   = 2'd2,
      GRAY_GREEN = 2'd3
   } gray_mode_e;

   localparam int          DEF_CH_W     = 8;
   localparam int          DEF_COEF_W   = 16;
   localparam int          DEF_CNT_W    = 24;
   // BT.601 luma weights in Q0.16; the three sum to exactly 1.0.
   localparam logic [15:0] DEF_COEF_R   = 16'h4C8B;
   localparam logic [15:0] DEF_COEF_G   = 16'h9646;
   localparam logic [15:0] DEF_COEF_B   = 16'h1D2F;
   localparam logic [15:0] DEF_COEF_AVG = 16'h5556;

   // Half an LSB of the integer result, added before truncation to round to nearest.
   function automatic int unsigned round_const(input int unsigned coef_w);
      return 32'd1 << (coef_w - 1);
   endfunction

endpackage

// File: rtl/rgb_gray_pipe_if.sv
// Pixel stream bundle: RGB input side and gray output side, each with valid/ready.
interface rgb_gray_pipe_if
   import gray_pkg::*;
#(
   parameter int CH_W = DEF_CH_W
);
   logic              in_valid;
   logic              in_ready;
   logic [3*CH_W-1:0] in_data;
   logic              in_last;
   gray_mode_e        mode;
   logic              out_valid;
   logic              out_ready;
   logic [CH_W-1:0]   out_data;
   logic              out_last;

   modport master (
      output in_valid, in_data, in_last, mode, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, in_last, mode, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/gray_coef_mul.sv
// Registered unsigned channel x coefficient multiplier; holds its product while en is low.
module gray_coef_mul #(
   parameter int A_W = 8,
   parameter int B_W = 16
) (
   input  logic               CLK,
   input  logic               en,
   input  logic [A_W-1:0]     a,
   input  logic [B_W-1:0]     b,
   output logic [A_W+B_W-1:0] p
);
   // NOTE: datapath register with no reset; the pipeline valid bits decide whether it means anything.
   always_ff @(posedge CLK) begin
      if (en) p <= (A_W+B_W)'(a) * (A_W+B_W)'(b);
   end
endmodule

// File: rtl/rgb_gray_pipe.sv
// Three-stage RGB-to-gray converter with per-pixel mode, frame-end sideband and output pixel counter.
// All stages advance together; a held output freezes the whole pipe (bubbles are kept).
module rgb_gray_pipe
   import gray_pkg::*;
#(
   parameter int                CH_W     = DEF_CH_W,
   parameter int                COEF_W   = DEF_COEF_W,
   parameter logic [COEF_W-1:0] COEF_R   = DEF_COEF_R,
   parameter logic [COEF_W-1:0] COEF_G   = DEF_COEF_G,
   parameter logic [COEF_W-1:0] COEF_B   = DEF_COEF_B,
   parameter logic [COEF_W-1:0] COEF_AVG = DEF_COEF_AVG,
   parameter int                CNT_W    = DEF_CNT_W
) (
   input  logic             CLK,
   input  logic             Clear,
   rgb_gray_pipe_if.slave   bus,
   input  logic             count_clr,
   output logic [CNT_W-1:0] pix_count
);
   localparam int                PROD_W = CH_W + COEF_W;
   localparam int                ACC_W  = PROD_W + 2;
   localparam logic [ACC_W-1:0]  RND    = ACC_W'(round_const(COEF_W));
   localparam logic [CH_W-1:0]   Y_MAX  = '1;

   logic              adv;
   logic              s1_valid, s1_last;
   logic [CH_W-1:0]   s1_r, s1_g, s1_b;
   gray_mode_e        s1_mode;
   logic [COEF_W-1:0] coef_r, coef_g, coef_b;
   logic [CH_W-1:0]   max_rg, pick;
   logic              s2_valid, s2_last;
   gray_mode_e        s2_mode;
   logic [CH_W-1:0]   s2_pick;
   logic [PROD_W-1:0] prod_r, prod_g, prod_b;
   logic [ACC_W-1:0]  acc, y_full;
   logic [CH_W-1:0]   y;
   logic              out_valid_q, out_last_q;
   logic [CH_W-1:0]   out_data_q;

   assign adv           = ~out_valid_q | bus.out_ready;
   assign bus.in_ready  = adv;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;

   // NOTE: sequential state uses <= so each stage samples its upstream neighbour's pre-edge value.
   always_ff @(posedge CLK or posedge Clear) begin
      if (Clear) begin
         s1_valid    <= 1'b0;
         s2_valid    <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else if (adv) begin
         s1_valid    <= bus.in_valid;
         s2_valid    <= s1_valid;
         out_valid_q <= s2_valid;
         out_last_q  <= s2_valid & s2_last;
         if (s2_valid) out_data_q <= y;
      end
   end

   always_ff @(posedge CLK) begin
      if (adv) begin
         {s1_r, s1_g, s1_b} <= bus.in_data;
         s1_mode            <= bus.mode;
         s1_last            <= bus.in_last;
         s2_mode            <= s1_mode;
         s2_last            <= s1_last;
         s2_pick            <= pick;
      end
   end

   // Average mode scales each channel by 1/3 in its own lane, which equals (R+G+B)*COEF_AVG exactly.
   // NOTE: every always_comb output is assigned a default first, so no path can infer a latch.
   always_comb begin
      coef_r = COEF_R;
      coef_g = COEF_G;
      coef_b = COEF_B;
      if (s1_mode == GRAY_AVG) begin
         coef_r = COEF_AVG;
         coef_g = COEF_AVG;
         coef_b = COEF_AVG;
      end
      max_rg = (s1_r > s1_g) ? s1_r : s1_g;
      pick   = s1_g;
      if (s1_mode == GRAY_MAX) pick = (max_rg > s1_b) ? max_rg : s1_b;
   end

   gray_coef_mul #(.A_W(CH_W), .B_W(COEF_W)) u_mul_r (
      .CLK(CLK), .en(adv), .a(s1_r), .b(coef_r), .p(prod_r)
   );
   gray_coef_mul #(.A_W(CH_W), .B_W(COEF_W)) u_mul_g (
      .CLK(CLK), .en(adv), .a(s1_g), .b(coef_g), .p(prod_g)
   );
   gray_coef_mul #(.A_W(CH_W), .B_W(COEF_W)) u_mul_b (
      .CLK(CLK), .en(adv), .a(s1_b), .b(coef_b), .p(prod_b)
   );

   always_comb begin
      acc    = ACC_W'(prod_r) + ACC_W'(prod_g) + ACC_W'(prod_b) + RND;
      y_full = acc >> COEF_W;
      y      = (|y_full[ACC_W-1:CH_W]) ? Y_MAX : y_full[CH_W-1:0];
      if (s2_mode == GRAY_MAX || s2_mode == GRAY_GREEN) y = s2_pick;
   end

   // A clear wins over a simultaneous transfer.
   always_ff @(posedge CLK or posedge Clear) begin
      if (Clear)                             pix_count <= '0;
      else if (count_clr)                    pix_count <= '0;
      else if (out_valid_q & bus.out_ready)  pix_count <= pix_count + CNT_W'(1);
   end
endmodule

// File: tb/tb_rgb_gray_pipe.sv
// Self-checking bench for rgb_gray_pipe: directed steps plus random traffic against an integer model.
module tb_rgb_gray_pipe;
   import gray_pkg::*;

   typedef struct {
      logic [7:0] data;
      logic       last;
   } exp_t;

   logic        CLK = 1'b0;
   logic        Clear;
   logic        count_clr, count_clr2;
   logic [23:0] pix_count;
   logic [3:0]  pix_count2;

   int          total = 0;
   int          bad = 0;
   int          n_out = 0;
   exp_t        exp_q[$];
   logic [23:0] exp_cnt;
   logic        hold_pend;
   logic [7:0]  hold_data;
   logic        hold_last;
   logic        accepted;

   rgb_gray_pipe_if #(.CH_W(8)) bus ();
   rgb_gray_pipe_if #(.CH_W(8)) bus2 ();

   rgb_gray_pipe u_dut (
      .CLK(CLK), .Clear(Clear), .bus(bus), .count_clr(count_clr), .pix_count(pix_count)
   );

   rgb_gray_pipe #(.CNT_W(4)) u_wrap (
      .CLK(CLK), .Clear(Clear), .bus(bus2), .count_clr(count_clr2), .pix_count(pix_count2)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Plain integer arithmetic on the written conversion rules.
   function automatic exp_t model(input logic [23:0] px, input int m, input logic last);
      int   r, g, b, y;
      exp_t e;
      r = int'(px[23:16]);
      g = int'(px[15:8]);
      b = int'(px[7:0]);
      case (m)
         0:       y = (r * 19595 + g * 38470 + b * 7471 + 32768) / 65536;
         1:       y = ((r + g + b) * 21846 + 32768) / 65536;
         2:       begin y = r; if (g > y) y = g; if (b > y) y = b; end
         default: y = g;
      endcase
      if (y > 255) y = 255;
      e.data = 8'(y);
      e.last = last;
      return e;
   endfunction

   // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
   task automatic cycle();
      exp_t e;
      logic ox, ix;
      #1;
      if (hold_pend) begin
         check("hold_valid", bus.out_valid, 1);
         check("hold_data", bus.out_data, hold_data);
         check("hold_last", bus.out_last, hold_last);
      end
      if (bus.out_valid && !bus.out_ready) check("stall_in_ready", bus.in_ready, 0);
      hold_pend = bus.out_valid && !bus.out_ready;
      hold_data = bus.out_data;
      hold_last = bus.out_last;
      ox = bus.out_valid && bus.out_ready;
      ix = bus.in_valid && bus.in_ready;
      accepted = ix;
      if (ox) begin
         check("out_expected", (exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_data", bus.out_data, e.data);
            check("out_last", bus.out_last, e.last);
            n_out++;
         end
      end
      if (ix) exp_q.push_back(model(bus.in_data, int'(bus.mode), bus.in_last));
      if (count_clr) exp_cnt = '0;
      else if (ox)   exp_cnt = exp_cnt + 24'd1;
      @(posedge CLK);
      #1;
      check("pix_count", pix_count, exp_cnt);
   endtask

   task automatic drain();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) cycle();
      check("drain_empty", exp_q.size(), 0);
   endtask

   // One pixel into an empty pipe; checks latency and a hand-computed result.
   task automatic single(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input int m, input logic [7:0] exp_y, input string tag);
      int lat;
      bus.in_valid  = 1'b1;
      bus.in_data   = {r, g, b};
      bus.mode      = gray_mode_e'(2'(m));
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      cycle();
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 8) begin
         cycle();
         lat++;
      end
      check({tag, "_latency"}, lat, 3);
      check(tag, bus.out_data, exp_y);
      cycle();
   endtask

   initial begin
      int sent;
      Clear         = 1'b0;
      count_clr     = 1'b0;
      count_clr2    = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.mode      = GRAY_LUMA;
      bus.out_ready = 1'b0;
      bus2.in_valid  = 1'b0;
      bus2.in_data   = '0;
      bus2.in_last   = 1'b0;
      bus2.mode      = GRAY_LUMA;
      bus2.out_ready = 1'b1;
      exp_cnt   = '0;
      hold_pend = 1'b0;
      accepted  = 1'b0;

      #1 Clear = 1'b1;
      #2;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_last", bus.out_last, 0);
      check("rst_pix_count", pix_count, 0);
      #20 Clear = 1'b0;
      #1 check("rst_in_ready", bus.in_ready, 1);
      @(posedge CLK);
      #1;

      single(8'd255, 8'd255, 8'd255, 0, 8'd255, "luma_white");
      single(8'd0,   8'd0,   8'd0,   0, 8'd0,   "luma_black");
      single(8'd255, 8'd0,   8'd0,   0, 8'd76,  "luma_red");
      single(8'd0,   8'd255, 8'd0,   0, 8'd150, "luma_green");
      single(8'd0,   8'd0,   8'd255, 0, 8'd29,  "luma_blue");
      single(8'd30,  8'd60,  8'd91,  1, 8'd60,  "avg");
      single(8'd255, 8'd255, 8'd255, 1, 8'd255, "avg_white");
      single(8'd10,  8'd200, 8'd45,  2, 8'd200, "max");
      single(8'd210, 8'd20,  8'd45,  2, 8'd210, "max_red");
      single(8'd10,  8'd200, 8'd45,  3, 8'd200, "green_hi");
      single(8'd10,  8'd7,   8'd45,  3, 8'd7,   "green_lo");

      // Mode changes on every accepted pixel.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 24'($urandom);
         bus.mode     = gray_mode_e'(2'(i));
         bus.in_last  = 1'b0;
         cycle();
      end
      drain();

      // Random traffic with random back-pressure.
      for (int i = 0; i < 120; i++) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_data   = 24'($urandom);
         bus.mode      = gray_mode_e'(2'($urandom));
         bus.in_last   = ($urandom_range(0, 7) == 0);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         cycle();
      end
      drain();

      // Ten pixels with a five-cycle output stall in the middle.
      n_out = 0;
      sent  = 0;
      for (int i = 0; i < 22; i++) begin
         bus.in_valid  = (sent < 10);
         bus.in_data   = 24'($urandom);
         bus.mode      = gray_mode_e'(2'($urandom));
         bus.in_last   = 1'b0;
         bus.out_ready = !(i >= 5 && i < 10);
         cycle();
         if (accepted) sent++;
      end
      drain();
      check("bp_sent", sent, 10);
      check("bp_out_count", n_out, 10);

      // Reset with three pixels in flight.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 24'($urandom);
         bus.mode     = gray_mode_e'(2'($urandom));
         cycle();
      end
      bus.in_valid = 1'b0;
      check("pre_rst_out_valid", bus.out_valid, 1);
      #2 Clear = 1'b1;
      #1;
      check("amid_out_valid", bus.out_valid, 0);
      check("amid_pix_count", pix_count, 0);
      check("amid_out_last", bus.out_last, 0);
      exp_q.delete();
      exp_cnt   = '0;
      hold_pend = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      Clear = 1'b0;
      #1 check("post_rst_in_ready", bus.in_ready, 1);
      @(posedge CLK);
      #1;
      single(8'd0, 8'd255, 8'd0, 0, 8'd150, "post_rst");

      // Frame marker and counter clearing.
      count_clr = 1'b1;
      cycle();
      count_clr = 1'b0;
      check("clr_idle", pix_count, 0);
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 24'($urandom);
         bus.mode     = gray_mode_e'(2'($urandom));
         bus.in_last  = (i == 3);
         cycle();
      end
      bus.in_last = 1'b0;
      drain();
      check("frame_count", pix_count, 4);

      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 24'($urandom);
      cycle();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 6 && !bus.out_valid; i++) cycle();
      check("clr_wait_valid", bus.out_valid, 1);
      bus.out_ready = 1'b1;
      count_clr     = 1'b1;
      cycle();
      count_clr = 1'b0;
      check("clr_with_xfer", pix_count, 0);

      // Narrow counter: 17 transfers wrap a 4-bit count to 1.
      for (int i = 0; i < 25; i++) begin
         bus2.in_valid = (i < 17);
         bus2.in_data  = 24'($urandom);
         @(posedge CLK);
         #1;
      end
      bus2.in_valid = 1'b0;
      check("wrap_count", pix_count2, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
